inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder.sv | 129 ++++++++++++
 tb/tb_inst_encoder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// RV32I instruction encoder with a one-entry output register and an address counter.
// Optional immediate range checking is compiled in with INST_ENCODER_RANGE_CHECK_EN.
module inst_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    input  logic        base_load,
    input  logic [31:0] base_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_addr,
    output logic        err
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_LW   = 3'd2;
    localparam logic [2:0] OP_SW   = 3'd3;
    localparam logic [2:0] OP_BEQ  = 3'd4;
    localparam logic [2:0] OP_BNE  = 3'd5;
    localparam logic [2:0] OP_BLT  = 3'd6;
    localparam logic [2:0] OP_JAL  = 3'd7;

    state_t      state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] enc_word;
    logic [31:0] word_addr;
    logic        accept;
    logic        illegal;
    logic        load;
    logic        unused_ok;

    // imm upper bits are only consumed by the range checker; low address bits never matter
    assign unused_ok = ^{imm[31:21], base_addr[1:0]};

    always_comb begin
        enc_word = 32'h0;
        case (op)
            OP_ADD:  enc_word = {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
            OP_ADDI: enc_word = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
            OP_LW:   enc_word = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
            OP_SW:   enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            OP_BEQ:  enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
            OP_BNE:  enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011};
            OP_BLT:  enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b100, imm[4:1], imm[11], 7'b1100011};
            OP_JAL:  enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            default: enc_word = 32'h0;
        endcase
    end

`ifdef INST_ENCODER_RANGE_CHECK_EN
    logic err_q;

    always_comb begin
        illegal = 1'b0;
        case (op)
            OP_ADDI, OP_LW, OP_SW:
                illegal = ($signed(imm) < -2048) || ($signed(imm) > 2047);
            OP_BEQ, OP_BNE, OP_BLT:
                illegal = imm[0] || ($signed(imm) < -4096) || ($signed(imm) > 4094);
            OP_JAL:
                illegal = imm[0] || ($signed(imm) < -1048576) || ($signed(imm) > 1048574);
            default: illegal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && illegal;
        end
    end

    assign err = err_q;
`else
    assign illegal = 1'b0;
    assign err     = 1'b0;
`endif

    assign in_ready = (state_q == EMPTY) || out_ready;
    assign accept   = in_valid && in_ready;
    assign load     = accept && !illegal;
    // base_load wins over the running count, for both the word address and the counter
    assign word_addr = base_load ? {base_addr[31:2], 2'b00} : cnt_q;

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        addr_d  = addr_q;
        cnt_d   = word_addr;
        if (load) begin
            inst_d  = enc_word;
            addr_d  = word_addr;
            cnt_d   = word_addr + 32'd4;
            state_d = FULL;
        end else if ((state_q == FULL) && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            inst_q  <= 32'h0;
            addr_q  <= 32'h0;
            cnt_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_inst  = inst_q;
    assign out_addr  = addr_q;
endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed scenarios plus random traffic
// against a queue-based reference model of the encoder and its address counter.
module tb_inst_encoder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0] imm = '0;
    logic        base_load = 1'b0;
    logic [31:0] base_addr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        err;

    inst_encoder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .base_load(base_load), .base_addr(base_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_cnt = '0;
    bit          m_err = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fld(input logic [31:0] x, input int hi, input int lo);
        return (x >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
    endfunction

    function automatic logic [31:0] ref_encode(input int o, input int d, input int s1,
                                               input int s2, input logic [31:0] im);
        int opc[8] = '{'h33, 'h13, 'h03, 'h23, 'h63, 'h63, 'h63, 'h6F};
        int f3[8]  = '{0, 0, 2, 2, 0, 1, 4, 0};
        logic [31:0] w;
        w = opc[o] + f3[o] * 32'h1000;
        if (o == 7) w = opc[o];
        case (o)
            0:       w += s2 * 32'h100000 + s1 * 32'h8000 + d * 32'h80;
            1, 2:    w += fld(im, 11, 0) * 32'h100000 + s1 * 32'h8000 + d * 32'h80;
            3:       w += fld(im, 11, 5) * 32'h2000000 + s2 * 32'h100000 + s1 * 32'h8000
                          + fld(im, 4, 0) * 32'h80;
            4, 5, 6: w += fld(im, 12, 12) * 32'h80000000 + fld(im, 10, 5) * 32'h2000000
                          + s2 * 32'h100000 + s1 * 32'h8000 + fld(im, 4, 1) * 32'h100
                          + fld(im, 11, 11) * 32'h80;
            default: w += fld(im, 20, 20) * 32'h80000000 + fld(im, 10, 1) * 32'h200000
                          + fld(im, 11, 11) * 32'h100000 + fld(im, 19, 12) * 32'h1000
                          + d * 32'h80;
        endcase
        return w;
    endfunction

    function automatic bit ref_legal(input int o, input logic [31:0] im);
`ifdef INST_ENCODER_RANGE_CHECK_EN
        int v;
        v = $signed(im);
        if (o >= 1 && o <= 3) return (v >= -2048) && (v <= 2047);
        if (o >= 4 && o <= 6) return (v >= -4096) && (v <= 4094) && (v % 2 == 0);
        if (o == 7) return (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
        return 1'b1;
`else
        return (o >= 0) || (im === im);
`endif
    endfunction

    task automatic drive(input bit v, input int o, input int d, input int s1, input int s2,
                         input logic [31:0] im, input bit bl, input logic [31:0] ba, input bit ordy);
        in_valid = v; op = o[2:0]; rd = d[4:0]; rs1 = s1[4:0]; rs2 = s2[4:0];
        imm = im; base_load = bl; base_addr = ba; out_ready = ordy;
    endtask

    // One clock: check outputs on the falling edge, advance the model, return just after the rising edge.
    task automatic tick();
        bit          acc;
        logic [31:0] waddr;
        @(negedge clk);
        check_val("in_ready", in_ready, (mq.size() == 0) || out_ready);
        check_val("out_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check_val("out_inst", out_inst, mq[0].inst);
            check_val("out_addr", out_addr, mq[0].addr);
        end
        check_val("err", err, m_err);
        acc = in_valid && ((mq.size() == 0) || out_ready);
        if ((mq.size() != 0) && out_ready) void'(mq.pop_front());
        waddr = base_load ? (base_addr & ~32'd3) : m_cnt;
        m_cnt = waddr;
        m_err = 1'b0;
        if (acc) begin
            if (ref_legal(int'(op), imm)) begin
                mq.push_back({ref_encode(int'(op), int'(rd), int'(rs1), int'(rs2), imm), waddr});
                m_cnt = waddr + 32'd4;
            end else begin
                m_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_out_addr", out_addr, 32'h0);
        check_val("rst_out_inst", out_inst, 32'h0);
        check_val("rst_err", err, 1'b0);
        mq.delete();
        m_cnt = '0;
        m_err = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_val("rst_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        int sel;
        logic [31:0] rimm;
        #1;
        do_reset();

        // ADDI rd=1 rs1=0 imm=5 right after reset
        drive(1, 1, 1, 0, 0, 32'd5, 0, 0, 0);
        tick();
        check_val("addi_valid", out_valid, 1'b1);
        check_val("addi_inst", out_inst, 32'h00500093);
        check_val("addi_addr", out_addr, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();

        // ADD then LW back-to-back with the sink always ready
        do_reset();
        drive(1, 0, 3, 1, 2, 32'd0, 0, 0, 1);
        tick();
        check_val("add_inst", out_inst, 32'h002081B3);
        check_val("add_addr", out_addr, 32'h0);
        drive(1, 2, 5, 2, 0, 32'd8, 0, 0, 1);
        tick();
        check_val("lw_valid", out_valid, 1'b1);
        check_val("lw_inst", out_inst, 32'h00812283);
        check_val("lw_addr", out_addr, 32'h4);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();

        // base_load coinciding with an accept
        drive(1, 3, 0, 2, 5, 32'd12, 1, 32'h100, 1);
        tick();
        check_val("sw_inst", out_inst, 32'h00512623);
        check_val("sw_addr", out_addr, 32'h100);
        drive(1, 1, 7, 7, 0, 32'd1, 0, 0, 1);
        tick();
        check_val("next_addr", out_addr, 32'h104);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();

        // BEQ stalled by the sink for three cycles, then delivered once
        drive(1, 4, 0, 1, 2, -32'sd8, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 1, 1, 0, 0, 0, 0);
            tick();
            check_val("beq_in_ready", in_ready, 1'b0);
            check_val("beq_inst", out_inst, 32'hFE208CE3);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        check_val("beq_once", out_valid, 1'b0);
        tick();

        // base_load while holding a word leaves the word alone
        drive(1, 1, 2, 0, 0, 32'd3, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 32'h2000, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        tick();

        // counter wraparound; low address bits ignored
        drive(1, 0, 1, 2, 3, 0, 1, 32'hFFFFFFFE, 1);
        tick();
        check_val("wrap_hi", out_addr, 32'hFFFFFFFC);
        drive(1, 0, 1, 2, 3, 0, 0, 0, 1);
        tick();
        check_val("wrap_lo", out_addr, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();

        // out-of-range ADDI immediate
        do_reset();
        drive(1, 1, 0, 0, 0, 32'd4096, 0, 0, 1);
        tick();
`ifdef INST_ENCODER_RANGE_CHECK_EN
        check_val("rc_no_valid", out_valid, 1'b0);
        check_val("rc_err", err, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        check_val("rc_err_pulse", err, 1'b0);
        drive(1, 1, 1, 0, 0, 32'd5, 0, 0, 1);
        tick();
        check_val("rc_cnt_kept", out_addr, 32'h0);
`else
        check_val("trunc_inst", out_inst, 32'h00000013);
        check_val("trunc_addr", out_addr, 32'h0);
`endif
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();

        // reset while FULL, then the next word restarts at address 0
        drive(1, 1, 1, 0, 0, 32'd5, 0, 0, 0);
        tick();
        tick();
        check_val("full_before_rst", out_valid, 1'b1);
        do_reset();
        drive(1, 0, 4, 5, 6, 0, 0, 0, 1);
        tick();
        check_val("post_rst_addr", out_addr, 32'h0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0:       rimm = $urandom;
                1:       rimm = $urandom_range(0, 2097151) - 32'd1048576;
                2:       rimm = $urandom_range(0, 8191) - 32'd4096;
                default: rimm = $urandom_range(0, 4095) - 32'd2048;
            endcase
            if ($urandom_range(0, 3) != 0) rimm[0] = 1'b0;
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 31), rimm,
                  $urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 9) < 6);
            tick();
            if ($urandom_range(0, 599) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
